// File: rtl/fifo_queue.sv
// Show-ahead synchronous FIFO with occupancy count, level flags
// and sticky overflow/underflow indicators.
module fifo_queue #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int ALMOST_FULL_LVL  = 12,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  FIFO_reset,
    input  logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  FIFO_save,
    input  logic                  FIFO_pop,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  FIFO_full,
    output logic                  FIFO_empty,
    output logic                  FIFO_almost_full,
    output logic                  FIFO_almost_empty,
    output logic [ADDR_WIDTH:0]   FIFO_count,
    output logic                  FIFO_overflow,
    output logic                  FIFO_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_en;
    logic                  rd_en;

    assign FIFO_full         = (count == DEPTH_CNT);
    assign FIFO_empty        = (count == '0);
    assign FIFO_almost_full  = (count >= AF_CNT);
    assign FIFO_almost_empty = (count <= AE_CNT);
    assign FIFO_count        = count;

    // A pop on a full queue frees the slot the concurrent write lands in.
    assign wr_en = FIFO_save && (!FIFO_full || FIFO_pop);
    assign rd_en = FIFO_pop && !FIFO_empty;

    assign O_DATA = FIFO_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!FIFO_reset && wr_en) begin
            mem[wr_ptr] <= I_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (FIFO_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            FIFO_overflow  <= 1'b0;
            FIFO_underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                wr_en && !rd_en: count <= count + 1'b1;
                rd_en && !wr_en: count <= count - 1'b1;
                default:         count <= count;
            endcase
            if (FIFO_save && FIFO_full && !FIFO_pop) begin
                FIFO_overflow <= 1'b1;
            end
            if (FIFO_pop && FIFO_empty) begin
                FIFO_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// Bench for fifo_queue: directed vector table, corner-case sequences
// and random traffic against a queue-based reference model.
module tb_fifo_queue;

    logic       clk = 1'b0;
    logic       FIFO_reset = 1'b0;
    logic [7:0] I_DATA = 8'h00;
    logic       FIFO_save = 1'b0;
    logic       FIFO_pop = 1'b0;
    logic [7:0] O_DATA;
    logic       FIFO_full;
    logic       FIFO_empty;
    logic       FIFO_almost_full;
    logic       FIFO_almost_empty;
    logic [4:0] FIFO_count;
    logic       FIFO_overflow;
    logic       FIFO_underflow;

    fifo_queue dut (
        .clk               (clk),
        .FIFO_reset        (FIFO_reset),
        .I_DATA            (I_DATA),
        .FIFO_save         (FIFO_save),
        .FIFO_pop          (FIFO_pop),
        .O_DATA            (O_DATA),
        .FIFO_full         (FIFO_full),
        .FIFO_empty        (FIFO_empty),
        .FIFO_almost_full  (FIFO_almost_full),
        .FIFO_almost_empty (FIFO_almost_empty),
        .FIFO_count        (FIFO_count),
        .FIFO_overflow     (FIFO_overflow),
        .FIFO_underflow    (FIFO_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int q[$];
    bit m_ovf;
    bit m_unf;

    typedef struct {
        logic       rst;
        logic       save;
        logic       pop;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic r, input logic s,
                                       input logic p, input logic [7:0] d);
        bit full;
        bit empty;
        bit do_pop;
        bit do_save;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        full    = (q.size() == 16);
        empty   = (q.size() == 0);
        do_pop  = p && !empty;
        do_save = s && (!full || p);
        if (s && full && !p) m_ovf = 1'b1;
        if (p && empty) m_unf = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (do_save) q.push_back(int'(d));
    endfunction

    task automatic check_model();
        int n;
        n = q.size();
        chk("count", 32'(FIFO_count), n);
        chk("dout", 32'(O_DATA), (n == 0) ? 0 : q[0]);
        chk("empty", 32'(FIFO_empty), 32'(n == 0));
        chk("full", 32'(FIFO_full), 32'(n == 16));
        chk("almost_full", 32'(FIFO_almost_full), 32'(n >= 12));
        chk("almost_empty", 32'(FIFO_almost_empty), 32'(n <= 2));
        chk("overflow", 32'(FIFO_overflow), 32'(m_ovf));
        chk("underflow", 32'(FIFO_underflow), 32'(m_unf));
    endtask

    task automatic cyc(input logic r, input logic s, input logic p,
                       input logic [7:0] d);
        FIFO_reset = r;
        FIFO_save  = s;
        FIFO_pop   = p;
        I_DATA     = d;
        @(posedge clk);
        model_step(r, s, p, d);
        #1;
        FIFO_reset = 1'b0;
        FIFO_save  = 1'b0;
        FIFO_pop   = 1'b0;
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1, 8'hA5, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1, 8'h3C, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h4D, 2, 8'h3C, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h5E, 2, 8'h4D, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h5E, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h77, 1, 8'h77, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h99, 0, 8'h00, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].save, tbl[i].pop, tbl[i].din);
            chk("tbl_count", 32'(FIFO_count), tbl[i].cnt);
            chk("tbl_dout", 32'(O_DATA), 32'(tbl[i].dout));
            chk("tbl_ovf", 32'(FIFO_overflow), 32'(tbl[i].ovf));
            chk("tbl_unf", 32'(FIFO_underflow), 32'(tbl[i].unf));
        end
        chk("rst_empty", 32'(FIFO_empty), 1);
        chk("rst_almost_empty", 32'(FIFO_almost_empty), 1);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i));
            chk("af_level", 32'(FIFO_almost_full), 32'((i + 1) >= 12));
        end
        chk("fill_full", 32'(FIFO_full), 1);
        chk("fill_count", 32'(FIFO_count), 16);
        cyc(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("ovf_set", 32'(FIFO_overflow), 1);
        chk("ovf_count", 32'(FIFO_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(O_DATA), i);
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", 32'(FIFO_empty), 1);
        chk("ovf_sticky", 32'(FIFO_overflow), 1);

        // Underflow stays sticky through traffic
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_set", 32'(FIFO_underflow), 1);
        chk("unf_dout", 32'(O_DATA), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h12);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_sticky", 32'(FIFO_underflow), 1);

        // Save+pop while full
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        chk("fullsp_count", 32'(FIFO_count), 16);
        chk("fullsp_ovf", 32'(FIFO_overflow), 0);
        chk("fullsp_dout", 32'(O_DATA), 32'h11);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fullsp_last", 32'(O_DATA), 32'h55);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fullsp_empty", 32'(FIFO_empty), 1);

        // Interleaved traffic around occupancy 3, wrapping pointers
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: cyc(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
                1: cyc(1'b0, 1'b0, 1'b1, 8'h00);
                default: cyc(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
            endcase
        end
        chk("wrap_count", 32'(FIFO_count), 3);

        // Reset beats a concurrent save at occupancy 9
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        chk("occ9", 32'(FIFO_count), 9);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("rstsave_count", 32'(FIFO_count), 0);
        chk("rstsave_empty", 32'(FIFO_empty), 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h3A);
        chk("rstsave_next", 32'(O_DATA), 32'h3A);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_queue.md
FIFO_QUEUE -- requirements
Module: fifo_queue

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 4, giving the storage depth DEPTH = 2^ADDR_WIDTH words (16 by default).
REQ-003 The block SHALL take parameter ALMOST_FULL_LVL, default 12, giving the occupancy at or above which almost-full asserts.
REQ-004 The block SHALL take parameter ALMOST_EMPTY_LVL, default 2, giving the occupancy at or below which almost-empty asserts.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and FIFO_reset, and this polarity and synchronicity are fixed.
REQ-006 The block SHALL provide the following ports (name, direction, width, meaning):
  - clk  in  1  master clock, all state on rising edge
  - FIFO_reset  in  1  synchronous active-high reset
  - I_DATA  in  DATA_WIDTH  write data
  - FIFO_save  in  1  write request, sampled each edge
  - FIFO_pop  in  1  read/advance request, sampled each edge
  - O_DATA  out  DATA_WIDTH  head word (show-ahead)
  - FIFO_full  out  1  occupancy == DEPTH
  - FIFO_empty  out  1  occupancy == 0
  - FIFO_almost_full  out  1  occupancy >= ALMOST_FULL_LVL
  - FIFO_almost_empty  out  1  occupancy <= ALMOST_EMPTY_LVL
  - FIFO_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
  - FIFO_overflow  out  1  sticky: write attempted while full
  - FIFO_underflow  out  1  sticky: pop attempted while empty

Function
REQ-007 Storage SHALL be a DEPTH x DATA_WIDTH array with write pointer, read pointer (ADDR_WIDTH bits each) and an occupancy counter (ADDR_WIDTH+1 bits).
REQ-008 An accepted write SHALL store I_DATA at the write pointer and increment the pointer modulo DEPTH at the same edge.
REQ-009 An accepted pop SHALL increment the read pointer modulo DEPTH; pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-010 O_DATA SHALL combinationally present the word at the read pointer when FIFO_empty=0, and SHALL be all-zero when FIFO_empty=1.
REQ-011 Show-ahead latency: a word written into an empty queue at edge k SHALL appear on O_DATA, with FIFO_empty=0, immediately after edge k.
REQ-012 Write-only conditions:
  - FIFO_save=1, FIFO_pop=0, not full: accept, count +1
  - FIFO_save=1, FIFO_pop=0, full: drop data, count unchanged, set FIFO_overflow
REQ-013 Pop-only conditions:
  - FIFO_pop=1, FIFO_save=0, not empty: accept, count -1
  - FIFO_pop=1, FIFO_save=0, empty: ignore, set FIFO_underflow
REQ-014 Simultaneous save and pop:
  - neither full nor empty: both accepted, count unchanged
  - full: both accepted (the pop frees the slot), count stays DEPTH, no overflow
  - empty: the write is accepted and the pop is ignored, count becomes 1, FIFO_underflow set
REQ-015 FIFO_full, FIFO_empty, FIFO_almost_full and FIFO_almost_empty SHALL be decoded from the registered count, so each reflects the state after the most recent edge.
REQ-016 FIFO_overflow and FIFO_underflow SHALL stay set until FIFO_reset; only reset clears them.
REQ-017 FIFO_count SHALL never exceed DEPTH and never wrap below 0.

Reset
REQ-018 On a rising edge with FIFO_reset=1, the block SHALL:
  - zero both pointers and the count
  - clear FIFO_overflow and FIFO_underflow
  - ignore FIFO_save and FIFO_pop in that cycle
REQ-019 After reset the outputs SHALL read O_DATA=0, FIFO_empty=1, FIFO_full=0, FIFO_almost_empty=1, FIFO_almost_full=0, FIFO_count=0.
REQ-020 Reset asserted mid-operation (any occupancy, any request) SHALL discard all contents in the same edge; array contents need no clearing.

Verification
REQ-021 The bench SHALL cover: reset, then write 0xA5 -> after that edge O_DATA=0xA5, FIFO_count=1, FIFO_empty=0, FIFO_almost_empty=1.
REQ-022 The bench SHALL cover: write 0x00..0x0F (16 words) -> FIFO_full=1, FIFO_count=16, FIFO_almost_full asserted from count 12; a 17th write of 0xFF -> FIFO_overflow=1, and the 16 pops return 0x00..0x0F in order.
REQ-023 The bench SHALL cover: a pop on an empty queue -> FIFO_underflow=1, count 0, O_DATA=0; FIFO_underflow stays 1 through later traffic until FIFO_reset.
REQ-024 The bench SHALL cover: fill to 16, then one cycle with save(0x55) and pop together -> count stays 16, no overflow, O_DATA = second word, and 0x55 is the last word out.
REQ-025 The bench SHALL cover: 40 interleaved writes/pops at occupancy about 3 -> pointer wrap exercised, output order identical to input order.
REQ-026 The bench SHALL cover: occupancy 9 with FIFO_reset and FIFO_save both asserted -> count 0, FIFO_empty=1, no word stored.
